// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and lane helpers for the load/store data RAM
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_W ? 4'hF : size == SZ_H ? 4'b0011 << lane : 4'b0001 << lane;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [31:0] s;
    s = word >> {lane, 3'b000};
    return size == SZ_W ? word
         : size == SZ_H ? {{16{~uns & s[15]}}, s[15:0]}
         : {{24{~uns & s[7]}}, s[7:0]};
  endfunction
endpackage

// File: rtl/lsu_ram_1rw.sv
// lsu_ram_1rw: single-port word RAM with byte-lane writes and synchronous read
module lsu_ram_1rw #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = $clog2(DEPTH_WORDS),
  parameter INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk)
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else
        rdata <= mem[addr];
    end
endmodule

// File: rtl/lsu_data_ram.sv
// lsu_data_ram: handshaked byte/half/word data memory with extension, wait states and error reporting
module lsu_data_ram
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0,
  parameter INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;

  state_t state, next;
  logic [CW-1:0] cnt;
  logic [1:0] lane, size_q, lane_q;
  logic accept, oor, mis, err, uns_q, err_q, ld_q;
  logic [31:0] wdata, ram_rdata;

  assign lane = req_addr_i[1:0];
  assign req_ready_o = state == IDLE || (state == RESP && rsp_ready_i);
  assign accept = req_valid_i && req_ready_o && !rst;
  assign oor = |(req_addr_i >> (AW + 2));
  assign mis = (req_size_i == SZ_H && req_addr_i[0]) || (req_size_i == SZ_W && |lane);
  assign err = oor || mis || req_size_i == 2'b11;
  assign wdata = req_size_i == SZ_W ? req_wdata_i
               : req_size_i == SZ_H ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};

  always_comb
    next = accept ? (WAIT_STATES > 0 ? WAIT : RESP)
         : state == WAIT && cnt == CW'(1) ? RESP
         : state == RESP && rsp_ready_i ? IDLE
         : state;

  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      ld_q  <= 1'b0;
    end else begin
      state <= next;
      cnt   <= accept ? CW'(WAIT_STATES) : state == WAIT ? cnt - 1'b1 : cnt;
      if (accept) begin
        err_q  <= err;
        ld_q   <= !err && !req_we_i;
        size_q <= req_size_i;
        lane_q <= lane;
        uns_q  <= req_unsigned_i;
      end
    end

  lsu_ram_1rw #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .en    (accept && !err),
    .we    (req_we_i),
    .be    (be_gen(req_size_i, lane)),
    .addr  (req_addr_i[AW+1:2]),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  assign rsp_valid_o = state == RESP;
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_rdata_o = rsp_valid_o && ld_q ? load_extend(ram_rdata, size_q, lane_q, uns_q) : '0;
endmodule
